conv_result_reader: RTL and testbench
=====================================

# conv_result_reader

Drains the convolution coprocessor's result register bank. On `start` it reads entries `0..len-1`, one per fetch, and presents each on a valid/ready output stream. Each entry is cleared as it is consumed. It sits between the result bank (read port and per-entry clear) and the host-side output interface.

## Interface

Parameters:
- `DATA_WIDTH`, default 8: width of each result entry.
- `DEPTH`, default 32: number of entries in the bank.
- `CLEAR_ON_READ`, default 1: 1 = pulse the entry clear on each handshake; 0 = never clear.

Ports:
- `clk`  in  1: clock. Single clock domain.
- `rstn`  in  1: reset, asynchronous, active-low.
- `start`  in  1: begin a drain. Honoured only in IDLE.
- `len`  in  $clog2(DEPTH+1): entry count. Sampled on an accepted `start`. Values above DEPTH saturate to DEPTH.
- `busy`  out  1: high in any state other than IDLE.
- `done`  out  1: one-cycle pulse at the end of a drain.
- `rd_addr`  out  $clog2(DEPTH): read index into the bank.
- `rd_data`  in  DATA_WIDTH: bank read data, combinational from `rd_addr`.
- `clrh_o`  out  1: clear strobe to the bank entry at `clr_addr`.
- `clr_addr`  out  $clog2(DEPTH): index of the entry being cleared.
- `m_valid`  out  1: output word valid.
- `m_ready`  in  1: downstream ready.
- `m_data`  out  DATA_WIDTH: output word.
- `m_last`  out  1: marks the final word of a drain.

## Operation

- States: IDLE, FETCH, SEND, DONE.
- IDLE:
  - `start` = 1 captures `len` into `cnt` and sets `idx` = 0.
  - If `len` = 0, go to DONE. No stream transfer occurs.
  - Otherwise go to FETCH.
- FETCH:
  - `rd_addr` = `idx`.
  - At the clock edge: `m_data` <= `rd_data`, `m_valid` <= 1, `m_last` <= (`idx` == `cnt`-1). Go to SEND.
- SEND:
  - `m_data`, `m_last` and `m_valid` are held stable until `m_valid & m_ready`.
  - On the handshake: `m_valid` <= 0.
  - If `m_last`, go to DONE. Otherwise `idx` <= `idx`+1 and go to FETCH.
- DONE: `done` = 1 for exactly one cycle, then go to IDLE.
- Clear:
  - `clrh_o` = `m_valid & m_ready & CLEAR_ON_READ` (combinational).
  - `clr_addr` = `idx`.
  - The bank entry clears on the same edge that completes the handshake.
- The bank's write enable has priority over clear. The bank writer must not write while `busy` = 1. This block does not check it.
- `start` while `busy` = 1 is ignored and does not affect the current drain.
- `m_ready` may be high before `m_valid`. `m_valid` never depends on `m_ready`.
- Width rules: `idx` never exceeds DEPTH-1, so there is no wrap-around. `cnt` is stored after saturation.

## Timing

- Reset values: state IDLE; `busy`, `done`, `m_valid`, `m_last`, `clrh_o` = 0; `m_data`, `rd_addr`, `clr_addr` = 0.
- Reset asserted mid-drain:
  - Immediate return to IDLE with all outputs at reset values.
  - No `done` pulse.
  - Entries not yet handshaken are left uncleared.
- Latency:
  - `start` edge to first `m_valid` high: 2 cycles (IDLE→FETCH, FETCH→SEND).
  - Peak throughput: one word per 2 cycles.
  - Each downstream stall cycle adds one cycle.
- Minimum drain time with `m_ready` tied high: 2·N + 2 cycles from `start` to `done`, including the DONE cycle.
- `done` is asserted the cycle after the last handshake. `busy` falls one cycle later.
- `len` = 0: `done` is asserted 1 cycle after `start`. `m_valid` and `clrh_o` stay 0.

## Structure

- Shared package `conv_pkg`:
  - State enum `rd_state_t` (IDLE, FETCH, SEND, DONE).
  - Default constants `CONV_DATA_WIDTH` = 8 and `CONV_DEPTH` = 32.
- Single module, no sub-modules: one state register, the `idx`/`cnt` counters, and the output holding register.

## Test plan

- `len`=4, bank = {0x11,0x22,0x33,0x44}, `m_ready`=1 → stream 0x11,0x22,0x33,0x44; `m_last` only on 0x44; `done` at cycle 10; all four entries read 0 afterwards.
- `len`=3, `m_ready` low for 5 cycles while the second word is valid → `m_data`=0x22 and `m_valid` held stable throughout; no `clrh_o` until the handshake; total cycles 8+5.
- `len`=0 → `done` one cycle after `start`; no `m_valid`; bank unchanged.
- `len`=40 with DEPTH=32 → exactly 32 words; `m_last` on index 31; `rd_addr` never exceeds 31.
- `start` re-pulsed during a drain of `len`=5 → ignored; exactly 5 words and one `done`.
- `rstn` pulsed low after 2 handshakes of a `len`=6 drain → `m_valid`, `busy` = 0 immediately; no `done`; entries 2..5 retain their values. CLEAR_ON_READ=0 run → bank fully unchanged.

Source files
------------

// File: rtl/conv_pkg.sv
// Shared types and default sizing for the convolution coprocessor blocks.
package conv_pkg;

  // Result-reader control states.
  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FETCH = 2'd1,
    SEND  = 2'd2,
    DONE  = 2'd3
  } rd_state_t;

  localparam int CONV_DATA_WIDTH = 8;
  localparam int CONV_DEPTH      = 32;

  // Clamp a requested entry count to the bank depth.
  function automatic int unsigned sat_count(input int unsigned req, input int unsigned depth);
    return (req > depth) ? depth : req;
  endfunction

endpackage

// File: rtl/conv_result_reader.sv
// Drains entries 0..len-1 of the result bank onto a valid/ready stream,
// clearing each entry on the edge that completes its handshake.
module conv_result_reader
  import conv_pkg::*;
#(
  parameter int DATA_WIDTH    = CONV_DATA_WIDTH,
  parameter int DEPTH         = CONV_DEPTH,
  parameter int CLEAR_ON_READ = 1,
  localparam int LW = $clog2(DEPTH + 1),
  localparam int AW = $clog2(DEPTH)
) (
  input  logic                  clk,
  input  logic                  rstn,
  input  logic                  start,
  input  logic [LW-1:0]         len,
  output logic                  busy,
  output logic                  done,
  output logic [AW-1:0]         rd_addr,
  input  logic [DATA_WIDTH-1:0] rd_data,
  output logic                  clrh_o,
  output logic [AW-1:0]         clr_addr,
  output logic                  m_valid,
  input  logic                  m_ready,
  output logic [DATA_WIDTH-1:0] m_data,
  output logic                  m_last
);

  localparam logic CLR_EN = (CLEAR_ON_READ != 0);
  localparam logic [LW-1:0] DEPTH_L = LW'(sat_count(DEPTH, DEPTH));

  rd_state_t             state_r;
  rd_state_t             state_s;
  logic [AW-1:0]         idx_r;
  logic [LW-1:0]         cnt_r;
  logic [DATA_WIDTH-1:0] m_data_r;
  logic                  m_valid_r;
  logic                  m_last_r;
  logic                  hs_s;
  logic [LW-1:0]         len_sat_s;

  assign hs_s      = m_valid_r & m_ready;
  assign len_sat_s = (len > DEPTH_L) ? DEPTH_L : len;

  // State register.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_r <= IDLE;
    end else begin
      state_r <= state_s;
    end
  end

  // Next-state decode; start is only looked at while idle.
  always_comb begin
    state_s = state_r;
    case (state_r)
      IDLE: begin
        if (start) begin
          if (len == LW'(0)) begin
            state_s = DONE;
          end else begin
            state_s = FETCH;
          end
        end else begin
          state_s = IDLE;
        end
      end
      FETCH: begin
        state_s = SEND;
      end
      SEND: begin
        if (hs_s) begin
          state_s = m_last_r ? DONE : FETCH;
        end else begin
          state_s = SEND;
        end
      end
      DONE: begin
        state_s = IDLE;
      end
      default: begin
        state_s = IDLE;
      end
    endcase
  end

  // Counters and output holding register; the word is frozen while in SEND.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      idx_r     <= AW'(0);
      cnt_r     <= LW'(0);
      m_data_r  <= {DATA_WIDTH{1'b0}};
      m_valid_r <= 1'b0;
      m_last_r  <= 1'b0;
    end else begin
      case (state_r)
        IDLE: begin
          if (start) begin
            cnt_r <= len_sat_s;
            idx_r <= AW'(0);
          end
        end
        FETCH: begin
          m_data_r  <= rd_data;
          m_valid_r <= 1'b1;
          m_last_r  <= (LW'(idx_r) == (cnt_r - LW'(1)));
        end
        SEND: begin
          if (hs_s) begin
            m_valid_r <= 1'b0;
            m_last_r  <= 1'b0;
            if (!m_last_r) begin
              idx_r <= idx_r + AW'(1);
            end
          end
        end
        default: begin
        end
      endcase
    end
  end

  assign busy     = (state_r != IDLE);
  assign done     = (state_r == DONE);
  assign rd_addr  = idx_r;
  assign clr_addr = idx_r;
  assign clrh_o   = hs_s & CLR_EN;
  assign m_valid  = m_valid_r;
  assign m_data   = m_data_r;
  assign m_last   = m_last_r;

endmodule

// File: tb/tb_conv_result_reader.sv
// Directed bench for conv_result_reader with a behavioural result bank.
module tb_conv_result_reader;

  logic       clk;
  logic       rstn;
  logic       start, start_b;
  logic [5:0] len, len_b;
  logic       busy, busy_b, done, done_b;
  logic [4:0] rd_addr, rd_addr_b, clr_addr, clr_addr_b;
  logic [7:0] rd_data, rd_data_b;
  logic       clrh_o, clrh_b;
  logic       m_valid, m_valid_b, m_ready, m_ready_b, m_last, m_last_b;
  logic [7:0] m_data, m_data_b;

  logic [7:0] bank   [0:31];
  logic [7:0] bank_b [0:31];
  logic [7:0] load_img [0:31];
  logic       load_req;

  int n_vec = 0;
  int n_err = 0;

  // per-drain observations
  logic [7:0] got_data [0:63];
  logic       got_last [0:63];
  logic [4:0] got_caddr [0:63];
  logic       got_clr [0:63];
  int n_hs, n_done, done_cyc, max_addr, mv_seen, clr_spur;
  logic busy_at_done, busy_after_done;

  conv_result_reader u_dut (
    .clk(clk), .rstn(rstn), .start(start), .len(len), .busy(busy), .done(done),
    .rd_addr(rd_addr), .rd_data(rd_data), .clrh_o(clrh_o), .clr_addr(clr_addr),
    .m_valid(m_valid), .m_ready(m_ready), .m_data(m_data), .m_last(m_last)
  );

  conv_result_reader #(.CLEAR_ON_READ(0)) u_dut_nc (
    .clk(clk), .rstn(rstn), .start(start_b), .len(len_b), .busy(busy_b), .done(done_b),
    .rd_addr(rd_addr_b), .rd_data(rd_data_b), .clrh_o(clrh_b), .clr_addr(clr_addr_b),
    .m_valid(m_valid_b), .m_ready(m_ready_b), .m_data(m_data_b), .m_last(m_last_b)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  assign rd_data   = bank[rd_addr];
  assign rd_data_b = bank_b[rd_addr_b];

  // Bank model: bulk load has priority over the per-entry clear.
  always @(posedge clk) begin
    if (load_req) begin
      for (int i = 0; i < 32; i++) begin
        bank[i]   <= load_img[i];
        bank_b[i] <= load_img[i];
      end
    end else begin
      if (clrh_o) bank[clr_addr] <= 8'h00;
      if (clrh_b) bank_b[clr_addr_b] <= 8'h00;
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic load_bank();
    load_req = 1'b1;
    @(negedge clk);
    load_req = 1'b0;
  endtask

  // Runs one drain on u_dut, one loop iteration per clock cycle (cycle 1 = start cycle).
  task automatic run_drain(input logic [5:0] l, input int stall_word, input int stall_cycles,
                           input logic [7:0] stall_exp, input int repulse_cyc,
                           input int rst_after_hs, input int max_cyc);
    int cyc;
    int stall_left;
    logic in_stall;
    n_hs = 0; n_done = 0; done_cyc = -1; max_addr = 0; mv_seen = 0; clr_spur = 0;
    busy_at_done = 1'b0; busy_after_done = 1'b1;
    stall_left = stall_cycles;
    @(negedge clk);
    cyc = 1;
    len = l;
    while (cyc <= max_cyc) begin
      start = (cyc == 1) || (cyc == repulse_cyc);
      if (cyc == repulse_cyc) len = 6'd2;
      #1;
      if (rst_after_hs > 0 && n_hs == rst_after_hs) begin
        rstn = 1'b0;
        #1;
        chk("rst_m_valid", m_valid, 1'b0);
        chk("rst_busy", busy, 1'b0);
        chk("rst_done", done, 1'b0);
        chk("rst_m_data", m_data, 8'h00);
        chk("rst_rd_addr", rd_addr, 5'd0);
        rstn = 1'b1;
        start = 1'b0;
        return;
      end
      if (int'(rd_addr) > max_addr) max_addr = int'(rd_addr);
      if (m_valid) mv_seen++;
      if (done) begin
        n_done++;
        if (done_cyc < 0) begin
          done_cyc = cyc;
          busy_at_done = busy;
        end
      end
      if (done_cyc >= 0 && cyc == done_cyc + 1) busy_after_done = busy;
      in_stall = m_valid && (n_hs == stall_word) && (stall_left > 0);
      if (in_stall) begin
        m_ready = 1'b0;
        stall_left--;
        chk("stall_data", m_data, stall_exp);
        chk("stall_valid", m_valid, 1'b1);
      end else begin
        m_ready = 1'b1;
      end
      #1;
      if (in_stall) chk("stall_clr", clrh_o, 1'b0);
      if (m_valid && m_ready) begin
        got_data[n_hs]  = m_data;
        got_last[n_hs]  = m_last;
        got_caddr[n_hs] = clr_addr;
        got_clr[n_hs]   = clrh_o;
        n_hs++;
      end else if (clrh_o) begin
        clr_spur++;
      end
      if (done_cyc >= 0 && cyc >= done_cyc + 3) break;
      @(negedge clk);
      cyc++;
    end
    start = 1'b0;
    m_ready = 1'b1;
  endtask

  initial begin
    int lastcnt;
    int nz;
    int hs_b, clr_b, done_b_seen;
    rstn = 1'b0; start = 1'b0; len = 6'd0; m_ready = 1'b1;
    start_b = 1'b0; len_b = 6'd0; m_ready_b = 1'b1; load_req = 1'b0;
    for (int i = 0; i < 32; i++) load_img[i] = 8'h5A;
    @(negedge clk);
    @(negedge clk);
    // reset state
    chk("rst_busy0", busy, 1'b0);
    chk("rst_done0", done, 1'b0);
    chk("rst_valid0", m_valid, 1'b0);
    chk("rst_last0", m_last, 1'b0);
    chk("rst_clr0", clrh_o, 1'b0);
    chk("rst_data0", m_data, 8'h00);
    chk("rst_addr0", rd_addr, 5'd0);
    chk("rst_caddr0", clr_addr, 5'd0);
    rstn = 1'b1;
    @(negedge clk);

    // T1: len=4, no back-pressure
    load_img[0] = 8'h11; load_img[1] = 8'h22; load_img[2] = 8'h33; load_img[3] = 8'h44;
    load_bank();
    run_drain(6'd4, -1, 0, 8'h00, -1, 0, 30);
    chk("t1_words", n_hs, 4);
    chk("t1_d0", got_data[0], 8'h11);
    chk("t1_d1", got_data[1], 8'h22);
    chk("t1_d2", got_data[2], 8'h33);
    chk("t1_d3", got_data[3], 8'h44);
    chk("t1_last", {got_last[3], got_last[2], got_last[1], got_last[0]}, 4'b1000);
    chk("t1_clr", {got_clr[3], got_clr[2], got_clr[1], got_clr[0]}, 4'b1111);
    chk("t1_caddr3", got_caddr[3], 5'd3);
    chk("t1_caddr1", got_caddr[1], 5'd1);
    chk("t1_done_cyc", done_cyc, 10);
    chk("t1_ndone", n_done, 1);
    chk("t1_busy_at_done", busy_at_done, 1'b1);
    chk("t1_busy_after", busy_after_done, 1'b0);
    chk("t1_clr_spur", clr_spur, 0);
    chk("t1_bank", {bank[0], bank[1], bank[2], bank[3], bank[4]}, 40'h00_00_00_00_5A);

    // T2: len=3, second word stalled for 5 cycles
    load_bank();
    run_drain(6'd3, 1, 5, 8'h22, -1, 0, 40);
    chk("t2_words", n_hs, 3);
    chk("t2_d1", got_data[1], 8'h22);
    chk("t2_d2", got_data[2], 8'h33);
    chk("t2_last", {got_last[2], got_last[1], got_last[0]}, 3'b100);
    chk("t2_done_cyc", done_cyc, 13);
    chk("t2_clr_spur", clr_spur, 0);

    // T3: len=0
    load_bank();
    run_drain(6'd0, -1, 0, 8'h00, -1, 0, 10);
    chk("t3_done_cyc", done_cyc, 2);
    chk("t3_valid", mv_seen, 0);
    chk("t3_words", n_hs, 0);
    chk("t3_clr", clr_spur, 0);
    chk("t3_bank", {bank[0], bank[1], bank[2], bank[3]}, 32'h11_22_33_44);

    // T4: len=40 saturates to 32
    for (int i = 0; i < 32; i++) load_img[i] = 8'(i + 1);
    load_bank();
    run_drain(6'd40, -1, 0, 8'h00, -1, 0, 100);
    chk("t4_words", n_hs, 32);
    for (int i = 0; i < 32; i++) chk("t4_data", got_data[i], 8'(i + 1));
    lastcnt = 0;
    for (int i = 0; i < 32; i++) if (got_last[i]) lastcnt++;
    chk("t4_last31", got_last[31], 1'b1);
    chk("t4_lastcnt", lastcnt, 1);
    chk("t4_max_addr", max_addr, 31);
    chk("t4_done_cyc", done_cyc, 66);
    nz = 0;
    for (int i = 0; i < 32; i++) if (bank[i] != 8'h00) nz++;
    chk("t4_bank_clear", nz, 0);

    // T5: start re-pulsed mid-drain
    load_bank();
    run_drain(6'd5, -1, 0, 8'h00, 4, 0, 40);
    chk("t5_words", n_hs, 5);
    chk("t5_ndone", n_done, 1);
    chk("t5_done_cyc", done_cyc, 12);
    chk("t5_d4", got_data[4], 8'h05);
    chk("t5_bank5", bank[5], 8'h06);

    // T6: reset after two handshakes of a len=6 drain
    for (int i = 0; i < 6; i++) load_img[i] = 8'hA0 + 8'(i);
    load_bank();
    run_drain(6'd6, -1, 0, 8'h00, -1, 2, 40);
    chk("t6_words", n_hs, 2);
    n_done = 0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      #1;
      if (done || busy || m_valid) n_done++;
    end
    chk("t6_quiet", n_done, 0);
    chk("t6_bank01", {bank[0], bank[1]}, 16'h0000);
    chk("t6_bank25", {bank[2], bank[3], bank[4], bank[5]}, 32'hA2_A3_A4_A5);

    // T7: CLEAR_ON_READ=0 instance leaves the bank intact
    load_img[0] = 8'h11; load_img[1] = 8'h22; load_img[2] = 8'h33;
    load_bank();
    start_b = 1'b1; len_b = 6'd3;
    hs_b = 0; clr_b = 0; done_b_seen = 0;
    for (int c = 0; c < 20; c++) begin
      @(negedge clk);
      start_b = 1'b0;
      #1;
      if (m_valid_b && m_ready_b) hs_b++;
      if (clrh_b) clr_b++;
      if (done_b) begin
        done_b_seen++;
        break;
      end
    end
    chk("t7_done", done_b_seen, 1);
    chk("t7_words", hs_b, 3);
    chk("t7_clr", clr_b, 0);
    @(negedge clk);
    chk("t7_bank", {bank_b[0], bank_b[1], bank_b[2]}, 24'h11_22_33);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
